regfile_mp: RTL and testbench

- Parametrised architectural register file with per-register rename status (busy bit and producing ROB tag), for the out-of-order core.
- Sits between decode/issue and the ROB.
- Provides NREAD combinational operand read ports with ROB value lookup and same-cycle rename/commit forwarding.
- Accepts one rename per cycle and up to NCOMMIT in-order commits per cycle; clears all dependencies on flush.

---
 rtl/regfile_mp_pkg.sv | 30 +++
 rtl/regfile_read_port.sv | 52 +++++
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants, types and helpers for the renamed architectural register file.
package regfile_mp_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned REG_W   = $clog2(NREG);
  localparam int unsigned ROB_W   = 4;
  localparam int unsigned ROB_R   = 1 << ROB_W;
  localparam int unsigned NREAD   = 2;
  localparam int unsigned NCOMMIT = 2;
  localparam int unsigned CNT_W   = $clog2(NREG + 1);

  typedef logic [$clog2(ROB_R)-1:0] rob_tag_t;

  // Where a read port takes its operand from, highest priority first.
  typedef enum logic [1:0] {
    SRC_REN = 2'd0,
    SRC_CMT = 2'd1,
    SRC_ROB = 2'd2,
    SRC_REG = 2'd3
  } rd_src_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NREG; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One operand read port: priority mux over rename, commit, ROB and register state.
module regfile_read_port
  import regfile_mp_pkg::*;
(
  input  logic [REG_W-1:0] id,
  input  logic             ren_valid,
  input  logic [REG_W-1:0] ren_rd,
  input  logic [ROB_W-1:0] ren_tag,
  input  logic             busy,
  input  logic [ROB_W-1:0] dep,
  input  logic [XLEN-1:0]  reg_val,
  input  logic             cmt_hit,
  input  logic [ROB_W-1:0] cmt_tag,
  input  logic [XLEN-1:0]  cmt_val,
  input  logic             rob_qrdy,
  input  logic [XLEN-1:0]  rob_qval,
  output logic [XLEN-1:0]  val,
  output logic             has_dep,
  output logic [ROB_W-1:0] dep_out
);

  rd_src_e src;

  // Pick the operand source in priority order.
  always_comb begin
    src = SRC_REG;
    if (ren_valid && (ren_rd == id) && (id != '0)) src = SRC_REN;
    else if (busy && cmt_hit && (cmt_tag == dep))  src = SRC_CMT;
    else if (busy)                                 src = SRC_ROB;
  end

  // Drive value, pending flag and producer tag for the selected source.
  always_comb begin
    val     = '0;
    has_dep = 1'b0;
    dep_out = '0;
    unique case (src)
      SRC_REN: begin
        has_dep = 1'b1;
        dep_out = ren_tag;
      end
      SRC_CMT: val = cmt_val;
      SRC_ROB: begin
        dep_out = dep;
        if (rob_qrdy) val = rob_qval;
        else          has_dep = 1'b1;
      end
      default: val = reg_val;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Architectural register file with per-register busy/ROB-tag rename status.
module regfile_mp
  import regfile_mp_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     ren_valid,
  input  logic [REG_W-1:0]         ren_rd,
  input  logic [ROB_W-1:0]         ren_tag,
  input  logic [NCOMMIT-1:0]       cmt_valid,
  input  logic [NCOMMIT*REG_W-1:0] cmt_rd,
  input  logic [NCOMMIT*XLEN-1:0]  cmt_val,
  input  logic [NCOMMIT*ROB_W-1:0] cmt_tag,
  input  logic [NREAD*REG_W-1:0]   rd_id,
  output logic [NREAD*XLEN-1:0]    rd_val,
  output logic [NREAD-1:0]         rd_has_dep,
  output logic [NREAD*ROB_W-1:0]   rd_dep,
  output logic [NREAD*ROB_W-1:0]   rob_qtag,
  input  logic [NREAD-1:0]         rob_qrdy,
  input  logic [NREAD*XLEN-1:0]    rob_qval,
  output logic [CNT_W-1:0]         busy_cnt
);

  logic [XLEN-1:0]  regs    [NREG];
  logic [ROB_W-1:0] dep     [NREG];
  logic [ROB_W-1:0] dep_nx  [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nx;

  logic [NREG-1:0]  cmt_hit;
  logic [ROB_W-1:0] cmt_wtag [NREG];
  logic [XLEN-1:0]  cmt_wval [NREG];

  // Per register, the highest-index commit port targeting it wins (later ports overwrite).
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cmt_hit[r]  = 1'b0;
      cmt_wtag[r] = '0;
      cmt_wval[r] = '0;
      for (int unsigned c = 0; c < NCOMMIT; c++) begin
        if (cmt_valid[c] && (r != 0) && (cmt_rd[c*REG_W +: REG_W] == REG_W'(r))) begin
          cmt_hit[r]  = 1'b1;
          cmt_wtag[r] = cmt_tag[c*ROB_W +: ROB_W];
          cmt_wval[r] = cmt_val[c*XLEN +: XLEN];
        end
      end
    end
  end

  // Next rename status: flush clears all, rename beats a matching commit clear.
  always_comb begin
    busy_nx = busy;
    for (int unsigned r = 0; r < NREG; r++) dep_nx[r] = dep[r];
    if (flush_in) begin
      busy_nx = '0;
      for (int unsigned r = 0; r < NREG; r++) dep_nx[r] = '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (ren_valid && (ren_rd == REG_W'(r))) begin
          busy_nx[r] = 1'b1;
          dep_nx[r]  = ren_tag;
        end else if (cmt_hit[r] && busy[r] && (dep[r] == cmt_wtag[r])) begin
          busy_nx[r] = 1'b0;
          dep_nx[r]  = '0;
        end
      end
    end
  end

  // State update; commits still write values on a flush cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy     <= '0;
      busy_cnt <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        dep[r]  <= '0;
      end
    end else if (rdy_in) begin
      busy     <= busy_nx;
      busy_cnt <= popcount(busy_nx);
      for (int unsigned r = 0; r < NREG; r++) begin
        dep[r] <= dep_nx[r];
        if (cmt_hit[r]) regs[r] <= cmt_wval[r];
      end
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [REG_W-1:0] id;
    assign id = rd_id[g*REG_W +: REG_W];

    regfile_read_port u_port (
      .id        (id),
      .ren_valid (ren_valid),
      .ren_rd    (ren_rd),
      .ren_tag   (ren_tag),
      .busy      (busy[id]),
      .dep       (dep[id]),
      .reg_val   (regs[id]),
      .cmt_hit   (cmt_hit[id]),
      .cmt_tag   (cmt_wtag[id]),
      .cmt_val   (cmt_wval[id]),
      .rob_qrdy  (rob_qrdy[g]),
      .rob_qval  (rob_qval[g*XLEN +: XLEN]),
      .val       (rd_val[g*XLEN +: XLEN]),
      .has_dep   (rd_has_dep[g]),
      .dep_out   (rd_dep[g*ROB_W +: ROB_W])
    );

    assign rob_qtag[g*ROB_W +: ROB_W] = rd_dep[g*ROB_W +: ROB_W];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: rename, commit, forwarding, flush, x0 and reset.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  logic                     clk_in = 1'b0;
  logic                     rst_n_in;
  logic                     rdy_in;
  logic                     flush_in;
  logic                     ren_valid;
  logic [REG_W-1:0]         ren_rd;
  logic [ROB_W-1:0]         ren_tag;
  logic [NCOMMIT-1:0]       cmt_valid;
  logic [NCOMMIT*REG_W-1:0] cmt_rd;
  logic [NCOMMIT*XLEN-1:0]  cmt_val;
  logic [NCOMMIT*ROB_W-1:0] cmt_tag;
  logic [NREAD*REG_W-1:0]   rd_id;
  logic [NREAD*XLEN-1:0]    rd_val;
  logic [NREAD-1:0]         rd_has_dep;
  logic [NREAD*ROB_W-1:0]   rd_dep;
  logic [NREAD*ROB_W-1:0]   rob_qtag;
  logic [NREAD-1:0]         rob_qrdy;
  logic [NREAD*XLEN-1:0]    rob_qval;
  logic [CNT_W-1:0]         busy_cnt;

  int vectors = 0;
  int miscompares = 0;

  regfile_mp dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
    .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep), .rd_dep(rd_dep),
    .rob_qtag(rob_qtag), .rob_qrdy(rob_qrdy), .rob_qval(rob_qval), .busy_cnt(busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush_in  = 1'b0;
    ren_valid = 1'b0;
    ren_rd    = '0;
    ren_tag   = '0;
    cmt_valid = '0;
    cmt_rd    = '0;
    cmt_val   = '0;
    cmt_tag   = '0;
    rob_qrdy  = '0;
    rob_qval  = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
    #1;
  endtask

  task automatic commit(input int p, input int rd, input logic [XLEN-1:0] v, input int tag);
    cmt_valid[p]                 = 1'b1;
    cmt_rd[p*REG_W +: REG_W]     = REG_W'(rd);
    cmt_val[p*XLEN +: XLEN]      = v;
    cmt_tag[p*ROB_W +: ROB_W]    = ROB_W'(tag);
  endtask

  task automatic rename(input int rd, input int tag);
    ren_valid = 1'b1;
    ren_rd    = REG_W'(rd);
    ren_tag   = ROB_W'(tag);
  endtask

  task automatic read_ids(input int id0, input int id1);
    rd_id = {REG_W'(id1), REG_W'(id0)};
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    idle();
    read_ids(5, 7);
    #12 rst_n_in = 1'b1;
    #1;
    check("reset_val0", rd_val[0 +: XLEN], 0);
    check("reset_dep", rd_has_dep, 0);
    check("reset_cnt", busy_cnt, 0);

    // 1: commit to a non-busy register
    commit(0, 5, 32'h1234, 3);
    tick();
    check("t1_val", rd_val[0 +: XLEN], 32'h1234);
    check("t1_hasdep", rd_has_dep[0], 0);
    check("t1_cnt", busy_cnt, 0);

    // 2: rename with same-cycle read forwarding, then ROB lookup
    rename(7, 2);
    #1;
    check("t2_fwd_has", rd_has_dep[1], 1);
    check("t2_fwd_dep", rd_dep[ROB_W +: ROB_W], 2);
    check("t2_fwd_qtag", rob_qtag[ROB_W +: ROB_W], 2);
    tick();
    check("t2_cnt", busy_cnt, 1);
    check("t2_pend_has", rd_has_dep[1], 1);
    check("t2_pend_dep", rd_dep[ROB_W +: ROB_W], 2);
    rob_qrdy[1] = 1'b1;
    rob_qval[XLEN +: XLEN] = 32'hAA;
    #1;
    check("t2_rob_val", rd_val[XLEN +: XLEN], 32'hAA);
    check("t2_rob_has", rd_has_dep[1], 0);
    check("t2_rob_qtag", rob_qtag[ROB_W +: ROB_W], 2);
    idle();

    // 3: commit clear loses to same-cycle rename of the same register
    commit(0, 7, 32'h55, 2);
    rename(7, 6);
    #1;
    check("t3_fwd_dep", rd_dep[ROB_W +: ROB_W], 6);
    check("t3_fwd_has", rd_has_dep[1], 1);
    tick();
    check("t3_has", rd_has_dep[1], 1);
    check("t3_dep", rd_dep[ROB_W +: ROB_W], 6);
    check("t3_cnt", busy_cnt, 1);

    // 4: two ports commit x9, highest port's tag/value wins
    rename(9, 4);
    tick();
    check("t4_cnt2", busy_cnt, 2);
    read_ids(9, 7);
    commit(0, 9, 32'h11, 1);
    commit(1, 9, 32'h44, 4);
    #1;
    check("t4_fwd_val", rd_val[0 +: XLEN], 32'h44);
    check("t4_fwd_has", rd_has_dep[0], 0);
    tick();
    check("t4_val", rd_val[0 +: XLEN], 32'h44);
    check("t4_has", rd_has_dep[0], 0);
    check("t4_cnt", busy_cnt, 1);

    // 4b: tag match on the lower port only does not clear x7
    commit(0, 7, 32'h66, 6);
    commit(1, 7, 32'h77, 1);
    #1;
    check("t4b_fwd_has", rd_has_dep[1], 1);
    check("t4b_fwd_dep", rd_dep[ROB_W +: ROB_W], 6);
    tick();
    check("t4b_cnt", busy_cnt, 1);

    // 5: flush with a commit and a dropped rename
    rename(10, 5);
    tick();
    rename(11, 7);
    tick();
    check("t5_cnt3", busy_cnt, 3);
    flush_in = 1'b1;
    commit(0, 3, 32'h99, 0);
    rename(12, 8);
    tick();
    read_ids(3, 7);
    #1;
    check("t5_x3", rd_val[0 +: XLEN], 32'h99);
    check("t5_x7", rd_val[XLEN +: XLEN], 32'h77);
    check("t5_has", rd_has_dep, 0);
    check("t5_cnt", busy_cnt, 0);
    read_ids(12, 10);
    #1;
    check("t5_dropped", rd_has_dep, 0);

    // 6: x0 is immune to rename and commit
    read_ids(0, 5);
    rename(0, 9);
    commit(0, 0, 32'hDEAD, 0);
    #1;
    check("t6_fwd_val", rd_val[0 +: XLEN], 0);
    check("t6_fwd_has", rd_has_dep[0], 0);
    check("t6_fwd_dep", rd_dep[0 +: ROB_W], 0);
    tick();
    check("t6_val", rd_val[0 +: XLEN], 0);
    check("t6_cnt", busy_cnt, 0);

    // rdy_in low freezes state
    rdy_in = 1'b0;
    commit(0, 5, 32'hBEEF, 0);
    rename(13, 3);
    tick();
    rdy_in = 1'b1;
    check("frz_val", rd_val[XLEN +: XLEN], 32'h1234);
    check("frz_cnt", busy_cnt, 0);

    // asynchronous reset mid-cycle
    rename(13, 3);
    tick();
    check("pre_rst_cnt", busy_cnt, 1);
    read_ids(13, 5);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("rst_val", rd_val[XLEN +: XLEN], 0);
    check("rst_has", rd_has_dep, 0);
    check("rst_cnt", busy_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
